// File: rtl/mem64_read_streamer.sv
// ---------------------------------------------------------------------------
// mem64_read_streamer
//
// Start-triggered, flow-controlled read engine for Memoria64. A burst walks
// 8-byte-aligned addresses from base_addr. Each word is captured MEM_LAT
// cycles after the memory samples its address. Captured words are buffered in
// a small skid FIFO and presented on a valid/ready stream. A credit check
// (FIFO occupancy + reads in flight < FIFO_DEPTH) keeps the FIFO from
// overflowing, so downstream back-pressure never loses a word.
//
// Optional feature (compile-time macro MEM64_RD_STALL_CNT_EN):
//   When defined, adds stall_cycles[31:0]. It counts cycles with
//   m_valid && !m_ready, is cleared when a start is accepted, and saturates.
//
// Ports:
//   clk          system clock, rising edge
//   nrst         asynchronous active-low reset
//   start        one-cycle burst request, sampled only in IDLE
//   base_addr    first byte address (bits [2:0] ignored)
//   num_words    burst length in 64-bit words (0 = empty burst)
//   mem_addr     Memoria64 Address
//   mem_wr       Memoria64 Wr (tied low)
//   mem_rdata    Memoria64 Dataout
//   m_valid      output word valid
//   m_ready      downstream accepts the word
//   m_data       output word
//   m_last       final word of the burst
//   busy         high from start acceptance until the done cycle
//   done         one-cycle pulse after the last word is accepted
//   stall_cycles back-pressure cycle count (MEM64_RD_STALL_CNT_EN only)
// ---------------------------------------------------------------------------
module mem64_read_streamer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 14,
    parameter int MEM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
`ifdef MEM64_RD_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Occupancy plus in-flight is at most 2*FIFO_DEPTH, so two extra bits suffice.
    localparam int CNT_W = PTR_W + 2;
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(7);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   remaining;

    // Latency pipe: one {valid, last} tag per cycle a read is outstanding.
    logic [MEM_LAT-1:0] pipe_v;
    logic [MEM_LAT-1:0] pipe_last;

    // Skid FIFO.
    logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
    logic               fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [CNT_W-1:0]   in_flight;
    logic               issue;
    logic               issue_last;
    logic               push;
    logic               pop;
    logic               drain_done;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default before anything else, so no latch can be inferred.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            in_flight = in_flight + CNT_W'(pipe_v[i]);
        end
    end

    // mem_addr always shows the address of the next word to read. Issuing
    // in a cycle means the memory samples it at the closing edge.
    assign issue      = (state == ISSUE) && ((count + in_flight) < CNT_W'(FIFO_DEPTH));
    assign issue_last = issue && (remaining == LEN_W'(1));

    assign push    = pipe_v[MEM_LAT-1];
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;

    // Head is gated with m_valid so stale storage never reaches the outputs.
    assign m_data = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last = m_valid && fifo_last[rd_ptr];

    // Burst is finished once nothing is in flight and the FIFO empties this
    // cycle. That lets done follow the final beat directly.
    assign drain_done = (pipe_v == '0) &&
                        ((count == '0) || ((count == CNT_W'(1)) && pop));

    assign mem_wr = 1'b0;

    // ---------------- latency pipe ----------------
    // NOTE: sequential state uses non-blocking '<=' so every register sees
    // values from before the edge, whatever order the statements appear in.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pipe_v    <= '0;
            pipe_last <= '0;
        end else begin
            pipe_v[0]    <= issue;
            pipe_last[0] <= issue_last;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    // ---------------- FIFO control ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the storage array has no reset. An empty FIFO is defined by the
    // pointers and count alone, and the head outputs are gated by m_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_last[wr_ptr] <= pipe_last[MEM_LAT-1];
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            remaining <= '0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= num_words;
                        busy      <= 1'b1;
                        if (num_words == '0) begin
                            // Empty burst: DRAIN sees nothing in flight, so
                            // busy holds for one cycle before the done pulse.
                            state <= DRAIN;
                        end else begin
                            mem_addr <= base_addr & ALIGN_MASK;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        remaining <= remaining - LEN_W'(1);
                        if (issue_last) begin
                            // Keep the final address presented. Later cycles
                            // re-read it harmlessly with no tag.
                            state <= DRAIN;
                        end else begin
                            mem_addr <= mem_addr + STRIDE;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM64_RD_STALL_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cycles <= '0;
        end else if (m_valid && !m_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem64_read_streamer.sv
// ---------------------------------------------------------------------------
// tb_mem64_read_streamer
//
// Self-checking bench for mem64_read_streamer.
// - A behavioural Memoria64 holds random contents and returns Dataout MEM_LAT
//   cycles after it samples the address.
// - The reference model expands each accepted burst into the list of expected
//   addresses and {last, data} beats.
// - A negedge monitor compares every accepted beat against that queue and
//   checks that head data holds under back-pressure.
// ---------------------------------------------------------------------------
module tb_mem64_read_streamer;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 64;
    localparam int LEN_W      = 14;
    localparam int MEM_LAT    = 1;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              nrst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  num_words = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              done;
`ifdef MEM64_RD_STALL_CNT_EN
    logic [31:0]       stall_cycles;
`endif

    always #5 clk = ~clk;

    mem64_read_streamer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .MEM_LAT(MEM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
`ifdef MEM64_RD_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .clk(clk),
        .nrst(nrst),
        .start(start),
        .base_addr(base_addr),
        .num_words(num_words),
        .mem_addr(mem_addr),
        .mem_wr(mem_wr),
        .mem_rdata(mem_rdata),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last),
        .busy(busy),
        .done(done)
    );

    // ---------------- behavioural Memoria64 ----------------
    logic [DATA_W-1:0] mem [8192];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];

    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= mem[mem_addr[15:3]];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // ---------------- model and observation state ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [64:0]       exp_q [$];
    logic [15:0]       exp_addr [$];
    logic [15:0]       addr_log [$];
    logic [15:0]       prev_addr = '0;
    logic              hold_pending = 1'b0;
    logic [DATA_W-1:0] held_data = '0;
    logic              busy_at_done = 1'b0;

    int cyc = 0;
    int start_cyc = 0;
    int beats = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_beat_cyc = -1;
    int first_valid_cyc = -1;
    int stall_obs = 0;

    always @(negedge clk) begin
        if (!nrst) begin
            prev_addr    = '0;
            hold_pending = 1'b0;
        end else begin
            cyc++;
            if (mem_addr !== prev_addr) begin
                addr_log.push_back(mem_addr);
                prev_addr = mem_addr;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hold_pending && m_valid) begin
                tests_run++;
                if (m_data !== held_data) begin
                    tests_failed++;
                    $display("FAIL hold_stable: got %h, required %h", m_data, held_data);
                end
            end
            hold_pending = m_valid && !m_ready;
            held_data    = m_data;
            if (m_valid && !m_ready) stall_obs++;
            if (m_valid && m_ready) begin
                logic [64:0] e;
                beats++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL beat_unexpected: got last=%b data=%h, required no beat",
                             m_last, m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        tests_failed++;
                        $display("FAIL beat%0d: got last=%b data=%h, required last=%b data=%h",
                                 beats, m_last, m_data, e[64], e[63:0]);
                    end
                end
                if (m_last) last_beat_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_burst(input logic [15:0] base, input logic [13:0] n);
        logic [15:0] a;
        addr_log.delete();
        exp_addr.delete();
        beats = 0; done_cnt = 0; done_cyc = -1; last_beat_cyc = -1;
        first_valid_cyc = -1; stall_obs = 0;
        for (int i = 0; i < int'(n); i++) begin
            a = (base & 16'hFFF8) + 16'(i * 8);
            exp_addr.push_back(a);
            exp_q.push_back({(i == int'(n) - 1), mem[a[15:3]]});
        end
        @(posedge clk); #1;
        base_addr = base; num_words = n; start = 1'b1;
        @(negedge clk); #1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 16'($urandom);
        num_words = 14'($urandom);
    endtask

    // mode 0: m_ready held high, 1: pattern 1,0,0,1, 2: random
    task automatic wait_done(input int mode, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
        m_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        nrst = 1'b1;
        #2 nrst = 1'b0;
        #3;
        tests_run++;
        if ({mem_addr, mem_wr, m_valid, m_data, m_last, busy, done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got addr=%h wr=%b v=%b data=%h last=%b busy=%b done=%b, required all 0",
                     mem_addr, mem_wr, m_valid, m_data, m_last, busy, done);
        end
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        bit ok;
        start_burst(16'h0008, 14'd4);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL basic_busy: got %b, required 1", busy);
        end
        tests_run++;
        if (mem_addr !== 16'h0008) begin
            tests_failed++; $display("FAIL basic_first_addr: got %h, required 0008", mem_addr);
        end
        wait_done(0, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL basic_timeout: got no done, required done");
        end
        tests_run++;
        if (addr_log.size() != exp_addr.size()) begin
            tests_failed++;
            $display("FAIL basic_addr_count: got %0d, required %0d", addr_log.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++) begin
            tests_run++;
            if (addr_log[i] !== exp_addr[i]) begin
                tests_failed++;
                $display("FAIL basic_addr%0d: got %h, required %h", i, addr_log[i], exp_addr[i]);
            end
        end
        tests_run++;
        if (beats != 4) begin
            tests_failed++; $display("FAIL basic_beats: got %0d, required 4", beats);
        end
        tests_run++;
        if (first_valid_cyc != start_cyc + 2 + MEM_LAT) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d, required %0d", first_valid_cyc - start_cyc, 2 + MEM_LAT);
        end
        tests_run++;
        if (done_cyc != last_beat_cyc + 1) begin
            tests_failed++;
            $display("FAIL basic_done_timing: got %0d, required %0d", done_cyc, last_beat_cyc + 1);
        end
        tests_run++;
        if (busy_at_done !== 1'b0) begin
            tests_failed++; $display("FAIL basic_busy_at_done: got %b, required 0", busy_at_done);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (done_cnt != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL basic_end: got done_cnt=%0d busy=%b left=%0d, required 1 0 0",
                     done_cnt, busy, exp_q.size());
        end
    endtask

    task automatic test_wrap;
        bit ok;
        start_burst(16'hFFF8, 14'd3);
        wait_done(0, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL wrap_timeout: got no done, required done");
        end
        tests_run++;
        if (addr_log.size() != 3) begin
            tests_failed++; $display("FAIL wrap_addr_count: got %0d, required 3", addr_log.size());
        end
        for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++) begin
            tests_run++;
            if (addr_log[i] !== exp_addr[i]) begin
                tests_failed++;
                $display("FAIL wrap_addr%0d: got %h, required %h", i, addr_log[i], exp_addr[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (beats != 3 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wrap_beats: got %0d left=%0d, required 3 left=0", beats, exp_q.size());
        end
    endtask

    task automatic test_zero_length;
        bit ok;
        logic [15:0] addr_before;
        addr_before = mem_addr;
        start_burst(16'h1230, 14'd0);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL zero_busy: got %b, required 1", busy);
        end
        wait_done(0, ok);
        tests_run++;
        if (!ok || done_cyc != start_cyc + 2) begin
            tests_failed++;
            $display("FAIL zero_done_timing: got %0d, required %0d", done_cyc - start_cyc, 2);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (first_valid_cyc != -1 || beats != 0) begin
            tests_failed++;
            $display("FAIL zero_no_valid: got first_valid=%0d beats=%0d, required none", first_valid_cyc, beats);
        end
        tests_run++;
        if (mem_addr !== addr_before || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_addr_hold: got addr=%h busy=%b, required addr=%h busy=0",
                     mem_addr, busy, addr_before);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        start_burst(16'h0100, 14'd16);
        wait_done(1, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL bp_timeout: got no done, required done");
        end
        tests_run++;
        if (beats != 16 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_beats: got %0d left=%0d, required 16 left=0", beats, exp_q.size());
        end
        tests_run++;
        if (done_cyc != last_beat_cyc + 1) begin
            tests_failed++;
            $display("FAIL bp_done_timing: got %0d, required %0d", done_cyc, last_beat_cyc + 1);
        end
`ifdef MEM64_RD_STALL_CNT_EN
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (stall_cycles !== 32'(stall_obs)) begin
            tests_failed++;
            $display("FAIL bp_stall_cycles: got %0d, required %0d", stall_cycles, stall_obs);
        end
`endif
    endtask

    task automatic test_random;
        bit ok;
        logic [15:0] b;
        logic [13:0] n;
        for (int r = 0; r < 4; r++) begin
            b = 16'($urandom);
            n = 14'($urandom_range(1, 40));
            start_burst(b, n);
            wait_done(2, ok);
            repeat (2) @(posedge clk);
            #1;
            tests_run++;
            if (!ok || beats != int'(n) || exp_q.size() != 0) begin
                tests_failed++;
                $display("FAIL random%0d: got ok=%b beats=%0d left=%0d, required beats=%0d left=0",
                         r, ok, beats, exp_q.size(), n);
            end
        end
    endtask

    task automatic test_start_ignored;
        start_burst(16'h0400, 14'd6);
        // Keep start high through the rest of the burst and its DONE cycle.
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) break;
            start = 1'b1; base_addr = 16'h2000; num_words = 14'd3;
        end
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        tests_run++;
        if (done_cnt != 1 || beats != 6 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL ignored_start: got done_cnt=%0d beats=%0d left=%0d, required 1 6 0",
                     done_cnt, beats, exp_q.size());
        end
        tests_run++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_idle: got busy=%b valid=%b, required 0 0", busy, m_valid);
        end
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        start_burst(16'h0800, 14'd10);
        for (int k = 0; k < 200 && beats < 5; k++) begin
            @(negedge clk); #1;
        end
        tests_run++;
        if (done_cnt != 0 || beats != 5) begin
            tests_failed++;
            $display("FAIL rst_pre: got done_cnt=%0d beats=%0d, required 0 5", done_cnt, beats);
        end
        nrst = 1'b0;
        #1;
        tests_run++;
        if ({mem_addr, mem_wr, m_valid, m_data, m_last, busy, done} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got addr=%h v=%b data=%h last=%b busy=%b done=%b, required all 0",
                     mem_addr, m_valid, m_data, m_last, busy, done);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (done_cnt != 0) begin
            tests_failed++; $display("FAIL rst_no_done: got %0d, required 0", done_cnt);
        end
        start_burst(16'h0040, 14'd2);
        wait_done(0, ok);
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (!ok || beats != 2 || done_cnt != 1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rst_after: got ok=%b beats=%0d done_cnt=%0d left=%0d, required 1 2 1 0",
                     ok, beats, done_cnt, exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = {$urandom, $urandom};
        test_reset();
        test_basic();
        test_wrap();
        test_zero_length();
        test_backpressure();
        test_random();
        test_start_ignored();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
